// File: rtl/count_job_arbiter.sv
// count_job_arbiter: two-requester round-robin arbiter feeding a modulo-N
// up/down step counter. A granted job loads a start value, takes len steps
// in the requested direction, then pulses done for one cycle.
module count_job_arbiter #(
   parameter int N = 10,
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2*W-1:0]   req_start,
   input  logic [2*W-1:0]   req_len,
   input  logic [1:0]       req_dir,
   input  logic             abort,
   output logic [W-1:0]     count,
   output logic             busy,
   output logic             grant_id,
   output logic             done,
   output logic             done_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic [W-1:0]   count_r;
   logic [W-1:0]   rem_r;
   logic [W-1:0]   start_r;
   logic [W-1:0]   len_r;
   logic           dir_r;
   logic           id_r;
   logic           prio_r;

   logic           win_s;
   logic           hs_s;
   logic [W-1:0]   sel_start_s;
   logic [W-1:0]   sel_len_s;
   logic           sel_dir_s;
   logic [1:0]     req_ready_s;
   logic           busy_s;
   logic           done_s;

   // Start values beyond the modulus are pinned to the largest legal count.
   function automatic logic [W-1:0] clamp_start(input logic [W-1:0] v);
      if ({1'b0, v} >= (W+1)'(N)) begin
         return W'(N - 1);
      end else begin
         return v;
      end
   endfunction

   // One modulo-N step in the given direction (1 = up, 0 = down).
   function automatic logic [W-1:0] step_count(input logic [W-1:0] c, input logic up);
      if (up) begin
         return (c == W'(N - 1)) ? W'(0) : c + W'(1);
      end else begin
         return (c == W'(0)) ? W'(N - 1) : c - W'(1);
      end
   endfunction

   // Arbitration: a lone valid requester wins, otherwise the pointer decides.
   always_comb begin
      win_s = prio_r;
      if (req_valid == 2'b01) begin
         win_s = 1'b0;
      end else if (req_valid == 2'b10) begin
         win_s = 1'b1;
      end else begin
         win_s = prio_r;
      end
   end

   // Mux the winning requester's job fields.
   always_comb begin
      sel_start_s = req_start[W-1:0];
      sel_len_s   = req_len[W-1:0];
      sel_dir_s   = req_dir[0];
      if (win_s) begin
         sel_start_s = req_start[2*W-1:W];
         sel_len_s   = req_len[2*W-1:W];
         sel_dir_s   = req_dir[1];
      end else begin
         sel_start_s = req_start[W-1:0];
         sel_len_s   = req_len[W-1:0];
         sel_dir_s   = req_dir[0];
      end
   end

   assign hs_s = |(req_valid & req_ready_s);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; abort only matters while a job is loading or running.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hs_s) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (len_r != W'(0)) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_DONE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (rem_r == W'(1)) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM outputs decoded from the state register; ready is held low during reset.
   always_comb begin
      busy_s      = 1'b0;
      done_s      = 1'b0;
      req_ready_s = 2'b00;
      case (state_r)
         ST_IDLE: begin
            busy_s = 1'b0;
            if (!rst && (req_valid != 2'b00)) begin
               req_ready_s = win_s ? 2'b10 : 2'b01;
            end else begin
               req_ready_s = 2'b00;
            end
         end
         ST_LOAD: begin
            busy_s = 1'b1;
         end
         ST_RUN: begin
            busy_s = 1'b1;
         end
         ST_DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Job datapath: latch on handshake, load, step, and hand the pointer over at job end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= W'(0);
         rem_r   <= W'(0);
         start_r <= W'(0);
         len_r   <= W'(0);
         dir_r   <= 1'b0;
         id_r    <= 1'b0;
         prio_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (hs_s) begin
                  id_r    <= win_s;
                  start_r <= clamp_start(sel_start_s);
                  len_r   <= sel_len_s;
                  dir_r   <= sel_dir_s;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  prio_r <= ~id_r;
               end else begin
                  count_r <= start_r;
                  rem_r   <= len_r;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  prio_r <= ~id_r;
               end else begin
                  count_r <= step_count(count_r, dir_r);
                  rem_r   <= rem_r - W'(1);
               end
            end
            ST_DONE: begin
               prio_r <= ~id_r;
            end
            default: begin
               prio_r <= prio_r;
            end
         endcase
      end
   end

   assign req_ready = req_ready_s;
   assign busy      = busy_s;
   assign done      = done_s;
   assign count     = count_r;
   assign grant_id  = id_r;
   assign done_id   = id_r;

endmodule

// File: tb/tb_count_job_arbiter.sv
// Bench for count_job_arbiter: directed and randomized jobs checked against a
// job-level model (round-robin pointer plus modular arithmetic on the count).
module tb_count_job_arbiter;

   localparam int N = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_start;
   logic [7:0] req_len;
   logic [1:0] req_dir;
   logic       abort;
   logic [3:0] count;
   logic       busy;
   logic       grant_id;
   logic       done;
   logic       done_id;

   int vectors     = 0;
   int miscompares = 0;
   int m_prio      = 0;
   int m_count     = 0;

   always #5 clk = ~clk;

   count_job_arbiter #(.N(N), .W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_start (req_start),
      .req_len   (req_len),
      .req_dir   (req_dir),
      .abort     (abort),
      .count     (count),
      .busy      (busy),
      .grant_id  (grant_id),
      .done      (done),
      .done_id   (done_id)
   );

   function automatic int mod_val(input int sc, input int k, input int up);
      if (up != 0) return (sc + k) % N;
      return (((sc - k) % N) + N) % N;
   endfunction

   // Runs one job from the handshake to the following IDLE cycle.
   // abort_at: -1 none, 0 LOAD cycle, j = j-th RUN cycle, len+1 = DONE cycle.
   task automatic run_job(input logic [1:0] v, input int s0, input int l0, input int d0,
                          input int s1, input int l1, input int d1, input int abort_at);
      int w, lb, s, l, d, sc, fin, exp_cnt;
      logic exp_busy, exp_done;
      logic [1:0] exp_ready;
      w  = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : m_prio;
      lb = 1 - w;
      s  = (w == 1) ? s1 : s0;
      l  = (w == 1) ? l1 : l0;
      d  = (w == 1) ? d1 : d0;
      sc = (s >= N) ? N - 1 : s;
      fin = (abort_at >= 0 && abort_at <= l) ? abort_at + 1 : l + 2;
      req_valid = v;
      req_start = {s1[3:0], s0[3:0]};
      req_len   = {l1[3:0], l0[3:0]};
      req_dir   = {d1[0], d0[0]};
      abort     = 1'b0;
      #1;
      exp_ready = (w == 1) ? 2'b10 : 2'b01;
      vectors++;
      if (req_ready !== exp_ready) begin
         miscompares++;
         $display("FAIL handshake_ready: got %b want %b", req_ready, exp_ready);
      end
      @(posedge clk);
      for (int c = 0; c <= fin; c++) begin
         @(negedge clk);
         if (c == fin) begin
            exp_busy = 1'b0; exp_done = 1'b0;
            if (fin == l + 2) exp_cnt = mod_val(sc, l, d);
            else if (abort_at == 0) exp_cnt = m_count;
            else exp_cnt = mod_val(sc, abort_at - 1, d);
            exp_ready = req_valid[lb] ? ((lb == 1) ? 2'b10 : 2'b01) : 2'b00;
         end else if (c == 0) begin
            exp_busy = 1'b1; exp_done = 1'b0; exp_cnt = m_count; exp_ready = 2'b00;
         end else if (c <= l) begin
            exp_busy = 1'b1; exp_done = 1'b0; exp_cnt = mod_val(sc, c - 1, d); exp_ready = 2'b00;
         end else begin
            exp_busy = 1'b1; exp_done = 1'b1; exp_cnt = mod_val(sc, l, d); exp_ready = 2'b00;
         end
         vectors++;
         if (count !== exp_cnt[3:0]) begin
            miscompares++;
            $display("FAIL count c=%0d: got %0d want %0d", c, count, exp_cnt);
         end
         vectors++;
         if (busy !== exp_busy) begin
            miscompares++;
            $display("FAIL busy c=%0d: got %b want %b", c, busy, exp_busy);
         end
         vectors++;
         if (done !== exp_done) begin
            miscompares++;
            $display("FAIL done c=%0d: got %b want %b", c, done, exp_done);
         end
         vectors++;
         if (grant_id !== w[0]) begin
            miscompares++;
            $display("FAIL grant_id c=%0d: got %b want %0d", c, grant_id, w);
         end
         vectors++;
         if (req_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL req_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
         end
         if (exp_done) begin
            vectors++;
            if (done_id !== w[0]) begin
               miscompares++;
               $display("FAIL done_id: got %b want %0d", done_id, w);
            end
         end
         // Drive the next cycle: winner drops valid, loser inputs churn.
         if (c == 0) begin
            req_valid[w] = 1'b0;
            req_start[w*4 +: 4] = 4'($urandom_range(0, 15));
            req_len[w*4 +: 4]   = 4'($urandom_range(0, 15));
            req_dir[w]          = 1'($urandom_range(0, 1));
         end
         if (c < fin) begin
            req_valid[lb]        = 1'($urandom_range(0, 1));
            req_start[lb*4 +: 4] = 4'($urandom_range(0, 15));
            req_len[lb*4 +: 4]   = 4'($urandom_range(0, 15));
            req_dir[lb]          = 1'($urandom_range(0, 1));
         end
         abort = (c == abort_at) ? 1'b1 : 1'b0;
      end
      abort     = 1'b0;
      req_valid = 2'b00;
      m_prio    = 1 - w;
      m_count   = exp_cnt;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b11; abort = 1'b0;
      req_start = 8'h00; req_len = 8'h00; req_dir = 2'b00;
      @(negedge clk); @(negedge clk);
      vectors++;
      if ({count, busy, done, done_id, grant_id, req_ready} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_state: got cnt=%0d busy=%b done=%b did=%b gid=%b rdy=%b want all zero",
                  count, busy, done, done_id, grant_id, req_ready);
      end
      m_prio = 0; m_count = 0;
      rst = 1'b0;
      // First edge with rst low must accept the job; pointer favours requester 0.
      run_job(2'b11, 4, 2, 1, 7, 2, 0, -1);
   endtask

   task automatic test_directed();
      run_job(2'b01, 3, 4, 1, 0, 0, 0, -1);
      run_job(2'b10, 0, 0, 0, 1, 3, 0, -1);
      run_job(2'b01, 12, 0, 1, 0, 0, 0, -1);
      run_job(2'b10, 0, 0, 0, 15, 2, 1, -1);
   endtask

   task automatic test_round_robin();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; m_prio = 0; m_count = 0;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (m_prio !== (k % 2)) begin
            miscompares++;
            $display("FAIL rr_order: model pointer %0d want %0d", m_prio, k % 2);
         end
         run_job(2'b11, 2 + k, 1 + k, 1, 5 + k, 2, 0, -1);
      end
   endtask

   task automatic test_abort();
      logic [3:0] held;
      run_job(2'b01, 2, 6, 1, 0, 0, 0, 2);
      run_job(2'b10, 0, 0, 0, 6, 3, 0, 0);
      run_job(2'b01, 5, 2, 0, 0, 0, 0, 3);
      run_job(2'b10, 0, 0, 0, 8, 5, 1, 1);
      held = count;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (busy !== 1'b0 || count !== m_count[3:0] || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_abort: got busy=%b cnt=%0d done=%b want 0/%0d/0 (was %0d)",
                  busy, count, done, m_count, held);
      end
   endtask

   task automatic test_reset_midrun();
      req_valid = 2'b01; req_start = 8'h05; req_len = 8'h08; req_dir = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      for (int k = 0; k < 4; k++) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({count, busy, done, grant_id, req_ready} !== 9'd0) begin
         miscompares++;
         $display("FAIL rst_midrun: got cnt=%0d busy=%b done=%b gid=%b rdy=%b want zeros",
                  count, busy, done, grant_id, req_ready);
      end
      @(negedge clk); @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_hold: got done=%b busy=%b want 0/0", done, busy);
      end
      rst = 1'b0; m_prio = 0; m_count = 0;
      run_job(2'b10, 0, 0, 0, 9, 3, 1, -1);
   endtask

   task automatic test_random();
      logic [1:0] v;
      int s0, l0, d0, s1, l1, d1, lw, ab;
      for (int it = 0; it < 40; it++) begin
         v  = 2'($urandom_range(1, 3));
         s0 = $urandom_range(0, 15); l0 = $urandom_range(0, 12); d0 = $urandom_range(0, 1);
         s1 = $urandom_range(0, 15); l1 = $urandom_range(0, 12); d1 = $urandom_range(0, 1);
         lw = (v == 2'b10 || (v == 2'b11 && m_prio == 1)) ? l1 : l0;
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lw + 1) : -1;
         run_job(v, s0, l0, d0, s1, l1, d1, ab);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; req_start = 8'h00; req_len = 8'h00;
      req_dir = 2'b00; abort = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_round_robin();
      test_abort();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
